// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel format and fill-engine state encoding.
package fb_pkg;

  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned PIXEL_W   = 12;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [PIXEL_W-1:0]   fb_pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fb_fill_state_e;

  // y*w without a multiplier for the native 320-pixel width (256+64).
  function automatic fb_addr_t row_offset(input fb_addr_t y, input int unsigned w);
    if (w == 320) return (y << 8) + (y << 6);
    return y * fb_addr_t'(w);
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational rectangle clip, range check and starting address for fb_rect_fill.
module fb_rect_clip
  import fb_pkg::*;
#(
  parameter int unsigned FB_W = fb_pkg::FB_W,
  parameter int unsigned FB_H = fb_pkg::FB_H
) (
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] width,
  input  logic [7:0] height,
  output fb_addr_t   xe,
  output fb_addr_t   ye,
  output fb_addr_t   row_base,
  output logic       skip,
  output logic       oob
);

  localparam fb_addr_t W_L = fb_addr_t'(FB_W);
  localparam fb_addr_t H_L = fb_addr_t'(FB_H);

  fb_addr_t x_l;
  fb_addr_t y_l;
  fb_addr_t x_end;
  fb_addr_t y_end;

  always_comb begin
    x_l      = fb_addr_t'(x0);
    y_l      = fb_addr_t'(y0);
    x_end    = x_l + fb_addr_t'(width);
    y_end    = y_l + fb_addr_t'(height);
    xe       = (x_end > W_L) ? W_L : x_end;
    ye       = (y_end > H_L) ? H_L : y_end;
    oob      = (x_l >= W_L) || (y_l >= H_L);
    skip     = oob || (width == '0) || (height == '0);
    row_base = row_offset(y_l, FB_W) + x_l;
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: writes one clipped pixel per cycle to framebuffer port A.
// Optional macro FB_FILL_VBLANK_GATE_EN restricts writes to vertical blank.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int unsigned FB_W = fb_pkg::FB_W,
  parameter int unsigned FB_H = fb_pkg::FB_H
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [7:0]  y0,
  input  logic [8:0]  width,
  input  logic [7:0]  height,
  input  logic [11:0] color,
  input  logic        vblank,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [11:0] fb_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  fb_fill_state_e state_q, state_d;
  logic [8:0]  x0_q, x0_d;
  logic [7:0]  y0_q, y0_d;
  logic [8:0]  w_q, w_d;
  logic [7:0]  h_q, h_d;
  fb_pixel_t   color_q, color_d;
  fb_addr_t    xe_q, xe_d;
  fb_addr_t    ye_q, ye_d;
  fb_addr_t    row_base_q, row_base_d;
  fb_addr_t    col_off_q, col_off_d;
  fb_addr_t    row_q, row_d;
  logic        we_q, we_d;
  fb_addr_t    addr_q, addr_d;
  fb_pixel_t   wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  fb_addr_t    clip_xe;
  fb_addr_t    clip_ye;
  fb_addr_t    clip_row_base;
  logic        clip_skip;
  logic        clip_oob;
  logic        gate;
  logic        advance;
  logic        x_last;
  logic        y_last;

  fb_rect_clip #(
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) u_clip (
    .x0       (x0_q),
    .y0       (y0_q),
    .width    (w_q),
    .height   (h_q),
    .xe       (clip_xe),
    .ye       (clip_ye),
    .row_base (clip_row_base),
    .skip     (clip_skip),
    .oob      (clip_oob)
  );

`ifdef FB_FILL_VBLANK_GATE_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign gate          = 1'b1;
  assign unused_vblank = vblank;
`endif

  // Counters only move on a cycle whose write actually reached the framebuffer.
  assign advance = (state_q == ST_FILL) && we_q && gate;
  assign x_last  = (fb_addr_t'(x0_q) + col_off_q + fb_addr_t'(1)) == xe_q;
  assign y_last  = (row_q + fb_addr_t'(1)) == ye_q;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    row_base_d = row_base_q;
    col_off_d  = col_off_q;
    row_d      = row_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = width;
          h_d     = height;
          color_d = color;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (clip_skip) begin
          done_d  = 1'b1;
          err_d   = clip_oob;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          xe_d       = clip_xe;
          ye_d       = clip_ye;
          row_base_d = clip_row_base;
          col_off_d  = '0;
          row_d      = fb_addr_t'(y0_q);
          we_d       = 1'b1;
          addr_d     = clip_row_base;
          wdata_d    = color_q;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (advance) begin
          if (x_last && y_last) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else if (x_last) begin
            col_off_d  = '0;
            row_base_d = row_base_q + fb_addr_t'(FB_W);
            row_d      = row_q + fb_addr_t'(1);
            addr_d     = row_base_q + fb_addr_t'(FB_W);
          end else begin
            col_off_d = col_off_q + fb_addr_t'(1);
            addr_d    = addr_q + fb_addr_t'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      row_base_q <= '0;
      col_off_q  <= '0;
      row_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      row_base_q <= row_base_d;
      col_off_q  <= col_off_d;
      row_q      <= row_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign fb_we    = we_q && gate;
  assign fb_addr  = addr_q;
  assign fb_wdata = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill against a raster-scan reference model.
module tb_fb_rect_fill;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  x0 = '0;
  logic [7:0]  y0 = '0;
  logic [8:0]  width = '0;
  logic [7:0]  height = '0;
  logic [11:0] color = '0;
  logic        vblank = 1'b1;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [11:0] fb_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int wa[$];
  int wd[$];
  int wc[$];
  int low_we = 0;
  bit done_seen = 0;
  int done_cyc = 0;
  logic done_err = 0;
  logic done_busy = 0;

  fb_rect_fill #(.FB_W(320), .FB_H(240)) dut (
    .clock(clock), .reset(reset), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .color(color), .vblank(vblank),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (fb_we) begin
      wa.push_back(int'(fb_addr));
      wd.push_back(int'(fb_wdata));
      wc.push_back(cyc);
      if (!vblank) low_we++;
    end
    if (done) begin
      done_seen = 1;
      done_cyc  = cyc;
      done_err  = err;
      done_busy = busy;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_fill(input int x, input int y, input int w, input int h,
                          input int col, input bit intrude, input bit gate_mode);
    int exp_q[$];
    int xe, ye, s, budget, n, k;
    int exp_err;
    xe = (x + w > 320) ? 320 : x + w;
    ye = (y + h > 240) ? 240 : y + h;
    exp_err = (x >= 320 || y >= 240) ? 1 : 0;
    if (!exp_err)
      for (int yy = y; yy < ye; yy++)
        for (int xx = x; xx < xe; xx++) exp_q.push_back(yy * 320 + xx);
    wa.delete(); wd.delete(); wc.delete();
    done_seen = 0; low_we = 0;
    @(posedge clock); #2;
    x0 = 9'(x); y0 = 8'(y); width = 9'(w); height = 8'(h); color = 12'(col);
    start = 1'b1;
    s = cyc;
    budget = (exp_q.size() + 4) * (gate_mode ? 3 : 1) + 20;
    for (k = 0; k < budget; k++) begin
      @(posedge clock); #2;
      start = 1'b0;
      if (intrude && k <= 2) begin
        start = 1'b1; x0 = 9'd0; y0 = 8'd0; width = 9'd50; height = 8'd50; color = 12'h0AB;
      end
      if (k == 0) chk("busy_after_start", int'(busy), 1);
`ifdef FB_FILL_VBLANK_GATE_EN
      vblank = gate_mode ? (((k / 3) % 2) == 0) : 1'b1;
`else
      vblank = 1'($urandom);
`endif
      if (done_seen) break;
    end
    start = 1'b0;
    vblank = 1'b1;
    chk("done_seen", int'(done_seen), 1);
    repeat (3) @(posedge clock);
    #2;
    chk("done_err", int'(done_err), exp_err);
    chk("done_busy", int'(done_busy), 0);
    chk("write_count", wa.size(), exp_q.size());
    n = (wa.size() < exp_q.size()) ? wa.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("write_addr", wa[i], exp_q[i]);
      chk("write_data", wd[i], col & 12'hFFF);
      if (!gate_mode) chk("write_cycle", wc[i], s + 2 + i);
    end
    if (gate_mode) chk("we_while_vblank_low", low_we, 0);
    else if (exp_q.size() == 0) chk("done_cycle_skip", done_cyc, s + 2);
    else if (wc.size() > 0) chk("done_cycle", done_cyc, wc[wc.size()-1] + 1);
  endtask

  task automatic reset_mid_fill();
    int n;
    wa.delete(); wd.delete(); wc.delete();
    @(posedge clock); #2;
    x0 = 9'd20; y0 = 8'd30; width = 9'd16; height = 8'd1; color = 12'h5A5;
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clock);
      if (fb_we) n++;
    end
    chk("rst_third_write_seen", n, 3);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_wdata", int'(fb_wdata), 0);
    @(posedge clock); #2;
    reset = 1'b0;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("rst_start_overridden", int'(busy), 0);
    chk("rst_no_more_writes", wa.size(), 3);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2;
    chk("reset_fb_we", int'(fb_we), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_addr", int'(fb_addr), 0);
    chk("reset_wdata", int'(fb_wdata), 0);
    reset = 1'b0;

    run_fill(10, 5, 4, 2, 'hF00, 0, 0);
    run_fill(318, 238, 10, 10, 'h0F0, 0, 0);
    run_fill(320, 0, 5, 5, 'h00F, 0, 0);
    run_fill(0, 240, 5, 5, 'h123, 0, 0);
    run_fill(10, 10, 0, 5, 'h321, 0, 0);
    run_fill(10, 10, 5, 0, 'h321, 0, 0);
    run_fill(319, 239, 1, 1, 'hABC, 0, 0);
    run_fill(50, 60, 5, 3, 'h777, 1, 0);
    reset_mid_fill();
    run_fill(7, 9, 6, 2, 'h9C3, 0, 0);

    for (int i = 0; i < 12; i++) begin
      int rx, ry;
      rx = (i % 3 == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 319));
      ry = (i % 4 == 0) ? int'($urandom_range(230, 245)) : int'($urandom_range(0, 239));
      run_fill(rx, ry, int'($urandom_range(0, 24)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 4095)), 1'($urandom), 0);
    end

`ifdef FB_FILL_VBLANK_GATE_EN
    run_fill(0, 0, 8, 1, 'hE1E, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
